modn_updown_counter: RTL

Parametrised modulo-N up/down counter digit with synchronous clear, parallel load, count enable and cascade outputs. It replaces the fixed mod-6 and mod-10 digit counters in the clock/timer datapath. A single instance covers any radix, and digits chain through a combinational terminal-count output plus registered carry/borrow pulses. It adds down-counting with borrow, load with out-of-range detection, and count enable, none of which the fixed-radix digits provide.

---
 rtl/modn_updown_counter.sv | 77 +++++++
 1 files changed

// File: rtl/modn_updown_counter.sv
// Modulo-N up/down digit counter with clear, parallel load, count enable and
// cascade outputs (combinational terminal count, registered carry/borrow pulses).
module modn_updown_counter #(
    parameter int unsigned MODULUS = 6,
    parameter int unsigned WIDTH   = $clog2(MODULUS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    input  logic             down,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             carry,
    output logic             borrow,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] MAX_COUNT   = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS itself is representable when 2^WIDTH == MODULUS.
    localparam logic [WIDTH:0]   MODULUS_EXT = (WIDTH + 1)'(MODULUS);

    logic at_max;
    logic at_zero;
    logic load_ok;

    // Wrap detection on the current (pre-step) value.
    always_comb begin
        at_max  = (count == MAX_COUNT);
        at_zero = (count == '0);
        load_ok = ({1'b0, load_value} < MODULUS_EXT);
        tc      = en & ~clear & ~load & ((~down & at_max) | (down & at_zero));
    end

    // Priority: clear > load > en > hold; carry/borrow are one-cycle pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            carry    <= 1'b0;
            borrow   <= 1'b0;
            load_err <= 1'b0;
        end else begin
            carry  <= 1'b0;
            borrow <= 1'b0;
            if (clear) begin
                count    <= '0;
                load_err <= 1'b0;
            end else if (load) begin
                if (load_ok) begin
                    count <= load_value;
                end else begin
                    count    <= '0;
                    load_err <= 1'b1;
                end
            end else if (en) begin
                if (!down) begin
                    if (at_max) begin
                        count <= '0;
                        carry <= 1'b1;
                    end else begin
                        count <= count + WIDTH'(1);
                    end
                end else begin
                    if (at_zero) begin
                        count  <= MAX_COUNT;
                        borrow <= 1'b1;
                    end else begin
                        count <= count - WIDTH'(1);
                    end
                end
            end
        end
    end

endmodule
